// File: rtl/rv_pkg.sv
// Shared RV32IM core definitions: sequencer state encoding, opcode map and
// writeback result-source selects.
package rv_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_MULDIV = 3'd5,
        ST_WB     = 3'd6,
        ST_FAULT  = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // States that block on an external handshake and are covered by the wait timer.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM) || (s == ST_MULDIV);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Saturating wait counter: clears on request, counts while enabled and flags
// when it has reached LIMIT.
module wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT_W);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32IM control sequencer: walks each instruction through
// fetch/decode/execute/memory/muldiv/writeback and drives datapath enables.
module multicycle_sequencer
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reg_write,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       branch,
    input  logic       jump,
    input  logic       illegal,
    input  logic       is_muldiv,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       md_start,
    input  logic       md_done,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       rf_we,
    output logic       retire,
    output logic       fault,
    output logic [2:0] state_o
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       awaited;
    logic       waiting;
    logic       expired;

    always_comb begin
        awaited = 1'b0;
        case (state_q)
            ST_FETCH:  awaited = imem_ready;
            ST_MEM:    awaited = dmem_ready;
            ST_MULDIV: awaited = md_done;
            default:   awaited = 1'b0;
        endcase
    end

    assign waiting = is_wait_state(state_q) && !awaited;

    // Any state change restarts the budget, so each wait state gets a full window.
    wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_d != state_q),
        .en_i     (waiting),
        .expired_o(expired)
    );

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        md_start = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = illegal ? ST_FAULT : ST_EXEC;
            end
            ST_EXEC: begin
                if (is_muldiv) begin
                    md_start = 1'b1;
                    state_d  = ST_MULDIV;
                end else if (mem_read || mem_write) begin
                    state_d = ST_MEM;
                end else if (branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready) begin
                    if (mem_write) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_MULDIV: begin
                if (md_done) begin
                    state_d = ST_WB;
                end else if (expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                rf_we   = reg_write;
                pc_we   = 1'b1;
                pc_sel  = jump;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
